// File: rtl/memory_stage.sv
// Memory stage of a simple in-order pipeline: non-memory instructions pass through,
// loads/stores issue a single memory request and stall upstream until mem_ready.
module memory_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bubble_in,
    input  logic [2:0]       opcode_in,
    input  logic [2:0]       tgt_in,
    input  logic [WIDTH-1:0] result_in,
    input  logic [WIDTH-1:0] store_data_in,
    input  logic             halt_in,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] wb_result,
    output logic [2:0]       wb_tgt,
    output logic             wb_bubble,
    output logic             wb_halt,
    output logic [15:0]      stall_count
);

    localparam logic [2:0] OpStore = 3'b100;
    localparam logic [2:0] OpLoad  = 3'b101;

    typedef enum logic [1:0] {StIdle, StBusy, StHalted} state_t;

    state_t     state;
    logic [2:0] tgt_lat;
    logic [2:0] opcode_lat;
    logic       halt_lat;

    assign stall = (state == StBusy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            tgt_lat     <= 3'd0;
            opcode_lat  <= 3'd0;
            halt_lat    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            wb_result   <= '0;
            wb_tgt      <= 3'd0;
            wb_bubble   <= 1'b1;
            wb_halt     <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (bubble_in) begin
                        wb_bubble <= 1'b1;
                        wb_tgt    <= 3'd0;
                        wb_halt   <= 1'b0;
                    end else if (opcode_in == OpLoad || opcode_in == OpStore) begin
                        tgt_lat    <= tgt_in;
                        opcode_lat <= opcode_in;
                        halt_lat   <= halt_in;
                        mem_req    <= 1'b1;
                        mem_we     <= (opcode_in == OpStore);
                        mem_addr   <= result_in;
                        mem_wdata  <= store_data_in;
                        wb_bubble  <= 1'b1;
                        wb_tgt     <= 3'd0;
                        wb_halt    <= 1'b0;
                        state      <= StBusy;
                    end else begin
                        wb_result <= result_in;
                        wb_tgt    <= tgt_in;
                        wb_bubble <= 1'b0;
                        wb_halt   <= halt_in;
                        if (halt_in) begin
                            state <= StHalted;
                        end
                    end
                end
                StBusy: begin
                    if (stall_count != 16'hFFFF) begin
                        stall_count <= stall_count + 16'd1;
                    end
                    // Request address/data/we stay untouched until the completing edge.
                    if (mem_ready) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        wb_bubble <= 1'b0;
                        wb_halt   <= halt_lat;
                        if (opcode_lat == OpLoad) begin
                            wb_result <= mem_rdata;
                            wb_tgt    <= tgt_lat;
                        end else begin
                            wb_tgt <= 3'd0;
                        end
                        state <= halt_lat ? StHalted : StIdle;
                    end
                end
                StHalted: begin
                    wb_bubble <= 1'b1;
                    wb_tgt    <= 3'd0;
                    wb_halt   <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the stage.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bubble_in = 1'b1;
    logic [2:0]  opcode_in = 3'd0;
    logic [2:0]  tgt_in = 3'd0;
    logic [15:0] result_in = 16'd0;
    logic [15:0] store_data_in = 16'd0;
    logic        halt_in = 1'b0;
    logic        stall, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic [15:0] wb_result;
    logic [2:0]  wb_tgt;
    logic        wb_bubble, wb_halt;
    logic [15:0] stall_count;

    int tests = 0;
    int fails = 0;

    // Model state: an outstanding memory transaction, sticky halt, expected outputs.
    bit          pending, p_load, p_halt, halted;
    logic [2:0]  p_tgt;
    logic        e_req, e_we, e_bubble, e_halt;
    logic [15:0] e_addr, e_wdata, e_result;
    logic [2:0]  e_tgt;
    int          e_cnt;

    memory_stage #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bubble_in(bubble_in), .opcode_in(opcode_in),
        .tgt_in(tgt_in), .result_in(result_in), .store_data_in(store_data_in),
        .halt_in(halt_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .wb_result(wb_result), .wb_tgt(wb_tgt),
        .wb_bubble(wb_bubble), .wb_halt(wb_halt), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pending = 0; halted = 0; p_load = 0; p_halt = 0; p_tgt = 3'd0;
        e_req = 0; e_we = 0; e_addr = 16'd0; e_wdata = 16'd0;
        e_result = 16'd0; e_tgt = 3'd0; e_bubble = 1; e_halt = 0; e_cnt = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        if (halted) begin
            e_bubble = 1; e_tgt = 3'd0; e_halt = 1;
        end else if (pending) begin
            if (e_cnt < 65535) e_cnt++;
            if (mem_ready) begin
                pending = 0; e_req = 0; e_we = 0; e_bubble = 0; e_halt = p_halt;
                if (p_load) begin
                    e_result = mem_rdata; e_tgt = p_tgt;
                end else begin
                    e_tgt = 3'd0;
                end
                if (p_halt) halted = 1;
            end
        end else if (bubble_in) begin
            e_bubble = 1; e_tgt = 3'd0; e_halt = 0;
        end else if (opcode_in == 3'b100 || opcode_in == 3'b101) begin
            pending = 1; p_load = (opcode_in == 3'b101); p_tgt = tgt_in; p_halt = halt_in;
            e_req = 1; e_we = !p_load; e_addr = result_in; e_wdata = store_data_in;
            e_bubble = 1; e_tgt = 3'd0; e_halt = 0;
        end else begin
            e_result = result_in; e_tgt = tgt_in; e_bubble = 0; e_halt = halt_in;
            if (halt_in) halted = 1;
        end
    endtask

    task automatic check_all();
        check("stall", 32'(stall), 32'(pending));
        check("mem_req", 32'(mem_req), 32'(e_req));
        check("mem_we", 32'(mem_we), 32'(e_we));
        if (e_req) begin
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
            check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        end
        check("wb_result", 32'(wb_result), 32'(e_result));
        check("wb_tgt", 32'(wb_tgt), 32'(e_tgt));
        check("wb_bubble", 32'(wb_bubble), 32'(e_bubble));
        check("wb_halt", 32'(wb_halt), 32'(e_halt));
        check("stall_count", 32'(stall_count), 32'(e_cnt));
    endtask

    task automatic cycle(input bit chk);
        model_step();
        @(posedge clk);
        #1;
        if (chk) check_all();
    endtask

    // Reset asynchronously mid-cycle, check immediately, release on the next falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input bit bub, input logic [2:0] op, input logic [2:0] tgt,
                         input logic [15:0] res, input logic [15:0] sd, input bit hlt);
        bubble_in = bub; opcode_in = op; tgt_in = tgt;
        result_in = res; store_data_in = sd; halt_in = hlt;
    endtask

    logic [2:0] nm;
    int         r;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rst_bubble", 32'(wb_bubble), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through on the first edge after reset release.
        drive(0, 3'b000, 3'd3, 16'h1234, 16'h0, 0);
        cycle(1);
        check("pt_result", 32'(wb_result), 32'h1234);
        check("pt_tgt", 32'(wb_tgt), 32'd3);
        check("pt_stall", 32'(stall), 32'd0);

        // Load with three wait cycles.
        do_reset();
        drive(0, 3'b101, 3'd5, 16'h0040, 16'h5555, 0);
        cycle(1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'b000, 3'd0, 16'hDEAD, 16'hDEAD, 0);
            cycle(1);
            check("ld_addr", 32'(mem_addr), 32'h0040);
            check("ld_we", 32'(mem_we), 32'd0);
            check("ld_stall", 32'(stall), 32'd1);
        end
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        cycle(1);
        mem_ready = 1'b0;
        check("ld_result", 32'(wb_result), 32'hBEEF);
        check("ld_tgt", 32'(wb_tgt), 32'd5);
        check("ld_count", 32'(stall_count), 32'd4);

        // Zero-wait store, then an immediate back-to-back pass-through.
        drive(0, 3'b100, 3'd6, 16'h0010, 16'h00AA, 0);
        cycle(1);
        check("st_we", 32'(mem_we), 32'd1);
        check("st_wdata", 32'(mem_wdata), 32'h00AA);
        drive(0, 3'b001, 3'd2, 16'h7777, 16'h0, 0);
        mem_ready = 1'b1; mem_rdata = 16'h9999;
        cycle(1);
        check("st_we_drop", 32'(mem_we), 32'd0);
        check("st_tgt", 32'(wb_tgt), 32'd0);
        check("st_bubble", 32'(wb_bubble), 32'd0);
        check("st_result_kept", 32'(wb_result), 32'hBEEF);
        cycle(1);
        check("b2b_result", 32'(wb_result), 32'h7777);
        mem_ready = 1'b0;

        // Halt carried by a load, then further loads are refused.
        drive(0, 3'b101, 3'd1, 16'h0020, 16'h0, 1);
        cycle(1);
        drive(0, 3'b101, 3'd4, 16'h0030, 16'h0, 0);
        mem_ready = 1'b1; mem_rdata = 16'h4321;
        cycle(1);
        check("hlt_result", 32'(wb_result), 32'h4321);
        check("hlt_flag", 32'(wb_halt), 32'd1);
        for (int i = 0; i < 12; i++) begin
            cycle(1);
            check("hlt_no_req", 32'(mem_req), 32'd0);
        end
        mem_ready = 1'b0;

        // Reset in the middle of a request; a late mem_ready must be harmless.
        do_reset();
        drive(0, 3'b101, 3'd7, 16'h0050, 16'h0, 0);
        cycle(1);
        drive(1, 3'b000, 3'd0, 16'h0, 16'h0, 0);
        cycle(1);
        do_reset();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_count", 32'(stall_count), 32'd0);
        mem_ready = 1'b1; mem_rdata = 16'hFFFF;
        cycle(1);
        check("late_bubble", 32'(wb_bubble), 32'd1);
        check("late_result", 32'(wb_result), 32'd0);
        mem_ready = 1'b0;

        // Randomized traffic; upstream holds its inputs while stall is expected.
        for (int i = 0; i < 600; i++) begin
            if (!pending) begin
                r = $urandom_range(0, 3);
                nm = 3'($urandom_range(0, 5));
                if (nm >= 3'd4) nm = nm + 3'd2;
                drive($urandom_range(0, 3) == 0, (r < 2) ? nm : ((r == 2) ? 3'b100 : 3'b101),
                      3'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 40) == 0);
            end
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = 16'($urandom);
            cycle(1);
            if (halted && $urandom_range(0, 4) == 0) do_reset();
        end
        mem_ready = 1'b0;

        // Saturation of the stall counter.
        do_reset();
        drive(0, 3'b101, 3'd2, 16'h0060, 16'h0, 0);
        cycle(1);
        drive(1, 3'b000, 3'd0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 70000; i++) cycle(0);
        check_all();
        check("sat_count", 32'(stall_count), 32'hFFFF);
        mem_ready = 1'b1; mem_rdata = 16'h0ABC;
        cycle(1);
        check("sat_hold", 32'(stall_count), 32'hFFFF);
        check("sat_result", 32'(wb_result), 32'h0ABC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter: WIDTH, 16, data/address width; all data, address and result ports are WIDTH bits.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: bubble_in  input  1  upstream slot is empty; all other upstream inputs are ignored.
REQ-005 Port: opcode_in  input  3  instruction opcode; 3'b100 = store, 3'b101 = load.
REQ-006 Port: tgt_in  input  3  destination register; 0 = no write.
REQ-007 Port: result_in  input  WIDTH  ALU result, which is also the memory address for load/store.
REQ-008 Port: store_data_in  input  WIDTH  forwarded store operand.
REQ-009 Port: halt_in  input  1  instruction is a halt.
REQ-010 Port: stall  output  1  upstream holds all its inputs stable while high.
REQ-011 Port: mem_req, mem_we  output  1 each  memory request, and write enable for that request.
REQ-012 Port: mem_addr, mem_wdata  output  WIDTH each  request address and store data.
REQ-013 Port: mem_ready  input  1  memory completes the current request this cycle.
REQ-014 Port: mem_rdata  input  WIDTH  load data; valid only when mem_ready is high.
REQ-015 Port: wb_result  output  WIDTH  writeback value.
REQ-016 Port: wb_tgt  output  3  writeback register; 0 = none.
REQ-017 Port: wb_bubble  output  1  writeback slot is empty.
REQ-018 Port: wb_halt  output  1  halt has reached writeback.
REQ-019 Port: stall_count  output  16  saturating count of cycles spent in BUSY.

Function
REQ-020 The FSM SHALL have three states, IDLE, BUSY and HALTED; stall SHALL equal (state==BUSY), driven from registered state only.
REQ-021 In IDLE with bubble_in=1 the block SHALL register: wb_bubble=1, wb_tgt=0, wb_halt=0, wb_result unchanged.
REQ-022 In IDLE, a valid non-memory instruction SHALL pass through with 1-cycle latency.
  - Next cycle: wb_result=result_in, wb_tgt=tgt_in, wb_bubble=0, wb_halt=halt_in.
REQ-023 In IDLE, a valid load or store SHALL be accepted as follows, and the block SHALL enter BUSY.
  - Latch: tgt_in, opcode_in, halt_in.
  - Next cycle: mem_req=1, mem_addr=result_in, mem_wdata=store_data_in, mem_we=(opcode_in==3'b100), wb_bubble=1, wb_tgt=0.
REQ-024 While BUSY with mem_ready=0, the block SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable.
  - Outputs: wb_bubble=1, wb_tgt=0.
  - stall_count increments by 1 per cycle and saturates at 16'hFFFF.
REQ-025 While BUSY with mem_ready=1, the block SHALL complete the request in that cycle and return to IDLE on the same edge.
  - Registered: mem_req=0, mem_we=0, wb_bubble=0, wb_halt=latched halt.
  - Load: wb_result=mem_rdata, wb_tgt=latched tgt.
  - Store: wb_tgt=0, wb_result unchanged.
REQ-026 Minimum load/store latency SHALL be 2 cycles from acceptance to wb_bubble=0, which occurs when mem_ready is high in the first BUSY cycle.
REQ-027 mem_ready SHALL be ignored whenever mem_req=0; mem_rdata SHALL be sampled only on a completing cycle.
REQ-028 A valid halt_in SHALL be handled at completion and make HALTED sticky until reset.
  - Completion: immediately for a non-memory instruction, at mem_ready for a load or store.
  - The completing cycle registers wb_halt=1, and the state becomes HALTED.
  - In HALTED: no new request is issued, wb_bubble=1, wb_tgt=0, wb_halt holds 1, stall=0, and all upstream inputs are ignored.
REQ-029 A back-to-back valid instruction presented on the cycle after completion SHALL be accepted with no dead cycle.
REQ-030 Address and data SHALL pass unmodified, with no arithmetic; stall_count SHALL never wrap.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously force the following:
  - state=IDLE, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - wb_result=0, wb_tgt=0, wb_bubble=1, wb_halt=0, stall_count=0.
REQ-032 Reset asserted while BUSY SHALL drop mem_req at once and abandon the request with no writeback.
  - A mem_ready arriving after reset has no effect.
REQ-033 After rst_n deasserts, the block SHALL accept a valid instruction on the first rising edge.

Verification
REQ-034 Pass-through: opcode 000, tgt=3, result_in=16'h1234 -> next cycle wb_result=16'h1234, wb_tgt=3, wb_bubble=0, stall=0.
REQ-035 Load, 3 wait cycles: opcode 101, result_in=16'h0040, tgt=5; mem_ready high on the 4th BUSY cycle with mem_rdata=16'hBEEF.
  - Response: stall high for 4 cycles, mem_addr=16'h0040 and mem_we=0 held stable throughout.
  - Then: wb_result=16'hBEEF, wb_tgt=5, stall_count=4.
REQ-036 Store, zero wait: opcode 100, result_in=16'h0010, store_data_in=16'h00AA; mem_ready in the first BUSY cycle.
  - Response: mem_we=1, mem_wdata=16'h00AA for exactly 1 cycle.
  - Then: wb_tgt=0, wb_bubble=0.
REQ-037 Halt: a halt on a load completes the load, then wb_halt=1.
  - Subsequent valid loads produce no mem_req for 10+ cycles.
REQ-038 Reset mid-request: rst_n low during BUSY -> mem_req=0 immediately, wb_bubble=1, stall_count=0.
  - A late mem_ready with mem_rdata=16'hFFFF produces no writeback.
REQ-039 Saturation: hold BUSY for 70000 cycles -> stall_count=16'hFFFF, with no wrap.
